memory_controller: RTL



---
 rtl/memory_controller.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Brief    : Byte-serial arbiter between fetch, load and store requesters and
//            the 8-bit unified RAM port.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef LB
`define LB  6'd1
`define LH  6'd2
`define LW  6'd3
`define LBU 6'd4
`define LHU 6'd5
`define SB  6'd6
`define SH  6'd7
`define SW  6'd8
`endif

module memory_controller (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       io_buffer_full,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [`XLEN-1:0]           mem_a,
    output logic                       mem_wr,
    input  logic                       if_enable,
    input  logic [`XLEN-1:0]           if_addr,
    output logic                       mc_inst_ready,
    output logic [`XLEN-1:0]           mc_inst,
    input  logic                       lsb_mem_enable,
    input  logic [`INST_OP_WIDTH-1:0]  lsb_mem_op,
    input  logic [`XLEN-1:0]           lsb_mem_addr,
    input  logic [`ROB_SIZE_WIDTH-1:0] lsb_mem_id,
    input  logic                       rob_mem_enable,
    input  logic [`INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [`XLEN-1:0]           rob_mem_addr,
    input  logic [`XLEN-1:0]           rob_mem_data,
    output logic                       mem_busy,
    output logic                       mem_data_ready,
    output logic [`XLEN-1:0]           mem_data,
    output logic [`ROB_SIZE_WIDTH-1:0] mem_id
);

    localparam int XW  = `XLEN;
    localparam int OPW = `INST_OP_WIDTH;
    localparam int IDW = `ROB_SIZE_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    function automatic logic [2:0] op_len(input logic [OPW-1:0] op);
        case (op)
            `LB, `LBU, `SB: op_len = 3'd1;
            `LH, `LHU, `SH: op_len = 3'd2;
            default:        op_len = 3'd4;
        endcase
    endfunction

    function automatic logic [XW-1:0] extend(input logic [OPW-1:0] op, input logic [XW-1:0] w);
        case (op)
            `LB:     extend = {{(XW-8){w[7]}}, w[7:0]};
            `LBU:    extend = {{(XW-8){1'b0}}, w[7:0]};
            `LH:     extend = {{(XW-16){w[15]}}, w[15:0]};
            `LHU:    extend = {{(XW-16){1'b0}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    logic [1:0]     state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [2:0]     len_q, len_d;
    logic [XW-1:0]  addr_q, addr_d;
    logic [XW-1:0]  word_q, word_d;
    logic [OPW-1:0] op_q, op_d;
    logic [IDW-1:0] id_q, id_d;

    logic           store_valid_q, store_valid_d;
    logic [OPW-1:0] store_op_q, store_op_d;
    logic [XW-1:0]  store_addr_q, store_addr_d;
    logic [XW-1:0]  store_data_q, store_data_d;
    logic           load_valid_q, load_valid_d;
    logic [OPW-1:0] load_op_q, load_op_d;
    logic [XW-1:0]  load_addr_q, load_addr_d;
    logic [IDW-1:0] load_id_q, load_id_d;

    logic [XW-1:0]  mem_a_q, mem_a_d;
    logic [7:0]     mem_dout_q, mem_dout_d;
    logic [XW-1:0]  mc_inst_q, mc_inst_d;
    logic           mc_inst_ready_q, mc_inst_ready_d;
    logic [XW-1:0]  mem_data_q, mem_data_d;
    logic           mem_data_ready_q, mem_data_ready_d;
    logic [IDW-1:0] mem_id_q, mem_id_d;

    logic           w_is_idle, w_is_read;
    logic           w_store_pend, w_load_pend;
    logic           w_start_store, w_start_load, w_start_fetch;
    logic           w_capture_store, w_capture_load;
    logic           w_io_stall, w_store_last, w_read_done;
    logic [2:0]     w_step_nxt;
    logic [XW-1:0]  w_step_ext;
    logic [XW-1:0]  w_read_word;
    logic [OPW-1:0] w_sel_store_op, w_sel_load_op;
    logic [XW-1:0]  w_sel_store_addr, w_sel_store_data, w_sel_load_addr;
    logic [IDW-1:0] w_sel_load_id;

    assign w_is_idle    = (state_q == S_IDLE);
    assign w_is_read    = (state_q == S_FETCH) || (state_q == S_LOAD);
    assign w_store_pend = store_valid_q | rob_mem_enable;
    assign w_load_pend  = (load_valid_q | lsb_mem_enable) & ~flush;

    assign w_start_store = w_is_idle & w_store_pend;
    assign w_start_load  = w_is_idle & ~w_store_pend & w_load_pend;
    assign w_start_fetch = w_is_idle & ~w_store_pend & ~w_load_pend & if_enable & ~flush;

    // A new request is parked unless it is being started straight from the ports.
    assign w_capture_store = rob_mem_enable & ~(w_start_store & ~store_valid_q);
    assign w_capture_load  = lsb_mem_enable & ~flush & ~(w_start_load & ~load_valid_q);

    assign w_sel_store_op   = store_valid_q ? store_op_q   : rob_mem_op;
    assign w_sel_store_addr = store_valid_q ? store_addr_q : rob_mem_addr;
    assign w_sel_store_data = store_valid_q ? store_data_q : rob_mem_data;
    assign w_sel_load_op    = load_valid_q  ? load_op_q    : lsb_mem_op;
    assign w_sel_load_addr  = load_valid_q  ? load_addr_q  : lsb_mem_addr;
    assign w_sel_load_id    = load_valid_q  ? load_id_q    : lsb_mem_id;

    assign w_step_nxt   = step_q + 3'd1;
    assign w_step_ext   = {{(XW-3){1'b0}}, w_step_nxt};
    assign w_io_stall   = (state_q == S_STORE) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
    assign w_store_last = (state_q == S_STORE) && !w_io_stall && (w_step_nxt == len_q);
    // step_q counts addressed bytes; mem_din holds byte step_q-1.
    assign w_read_done  = w_is_read && (step_q == len_q);

    always_comb begin
        w_read_word = word_q;
        case (step_q)
            3'd1:    w_read_word[7:0]   = mem_din;
            3'd2:    w_read_word[15:8]  = mem_din;
            3'd3:    w_read_word[23:16] = mem_din;
            3'd4:    w_read_word[31:24] = mem_din;
            default: w_read_word = word_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_store)      state_d = S_STORE;
                else if (w_start_load)  state_d = S_LOAD;
                else if (w_start_fetch) state_d = S_FETCH;
            end
            S_FETCH, S_LOAD: begin
                if (flush || w_read_done) state_d = S_IDLE;
            end
            S_STORE: begin
                if (w_store_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d           = step_q;
        len_d            = len_q;
        addr_d           = addr_q;
        word_d           = word_q;
        op_d             = op_q;
        id_d             = id_q;
        mem_a_d          = mem_a_q;
        mem_dout_d       = mem_dout_q;
        mc_inst_d        = mc_inst_q;
        mem_data_d       = mem_data_q;
        mem_id_d         = mem_id_q;
        mc_inst_ready_d  = 1'b0;
        mem_data_ready_d = 1'b0;

        store_valid_d = (store_valid_q & ~w_start_store) | w_capture_store;
        store_op_d    = w_capture_store ? rob_mem_op   : store_op_q;
        store_addr_d  = w_capture_store ? rob_mem_addr : store_addr_q;
        store_data_d  = w_capture_store ? rob_mem_data : store_data_q;
        load_valid_d  = ~flush & ((load_valid_q & ~w_start_load) | w_capture_load);
        load_op_d     = w_capture_load ? lsb_mem_op   : load_op_q;
        load_addr_d   = w_capture_load ? lsb_mem_addr : load_addr_q;
        load_id_d     = w_capture_load ? lsb_mem_id   : load_id_q;

        if (w_start_store) begin
            op_d       = w_sel_store_op;
            len_d      = op_len(w_sel_store_op);
            addr_d     = w_sel_store_addr;
            word_d     = w_sel_store_data;
            step_d     = 3'd0;
            mem_a_d    = w_sel_store_addr;
            mem_dout_d = w_sel_store_data[7:0];
        end else if (w_start_load) begin
            op_d    = w_sel_load_op;
            len_d   = op_len(w_sel_load_op);
            addr_d  = w_sel_load_addr;
            id_d    = w_sel_load_id;
            word_d  = '0;
            step_d  = 3'd0;
            mem_a_d = w_sel_load_addr;
        end else if (w_start_fetch) begin
            len_d   = 3'd4;
            addr_d  = if_addr;
            word_d  = '0;
            step_d  = 3'd0;
            mem_a_d = if_addr;
        end else if (w_is_read && !flush) begin
            word_d = w_read_word;
            step_d = w_step_nxt;
            if (w_step_nxt < len_q) mem_a_d = addr_q + w_step_ext;
            if (w_read_done) begin
                if (state_q == S_LOAD) begin
                    mem_data_d       = extend(op_q, w_read_word);
                    mem_id_d         = id_q;
                    mem_data_ready_d = 1'b1;
                end else if (if_addr == addr_q) begin
                    // A moved fetch address discards the word; IDLE refetches.
                    mc_inst_d       = w_read_word;
                    mc_inst_ready_d = 1'b1;
                end
            end
        end else if ((state_q == S_STORE) && !w_io_stall && !w_store_last) begin
            step_d  = w_step_nxt;
            mem_a_d = addr_q + w_step_ext;
            case (w_step_nxt)
                3'd1:    mem_dout_d = word_q[15:8];
                3'd2:    mem_dout_d = word_q[23:16];
                3'd3:    mem_dout_d = word_q[31:24];
                default: mem_dout_d = word_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q           <= '0;
            len_q            <= '0;
            addr_q           <= '0;
            word_q           <= '0;
            op_q             <= '0;
            id_q             <= '0;
            store_valid_q    <= 1'b0;
            store_op_q       <= '0;
            store_addr_q     <= '0;
            store_data_q     <= '0;
            load_valid_q     <= 1'b0;
            load_op_q        <= '0;
            load_addr_q      <= '0;
            load_id_q        <= '0;
            mem_a_q          <= '0;
            mem_dout_q       <= '0;
            mc_inst_q        <= '0;
            mc_inst_ready_q  <= 1'b0;
            mem_data_q       <= '0;
            mem_data_ready_q <= 1'b0;
            mem_id_q         <= '0;
        end else if (rdy) begin
            step_q           <= step_d;
            len_q            <= len_d;
            addr_q           <= addr_d;
            word_q           <= word_d;
            op_q             <= op_d;
            id_q             <= id_d;
            store_valid_q    <= store_valid_d;
            store_op_q       <= store_op_d;
            store_addr_q     <= store_addr_d;
            store_data_q     <= store_data_d;
            load_valid_q     <= load_valid_d;
            load_op_q        <= load_op_d;
            load_addr_q      <= load_addr_d;
            load_id_q        <= load_id_d;
            mem_a_q          <= mem_a_d;
            mem_dout_q       <= mem_dout_d;
            mc_inst_q        <= mc_inst_d;
            mc_inst_ready_q  <= mc_inst_ready_d;
            mem_data_q       <= mem_data_d;
            mem_data_ready_q <= mem_data_ready_d;
            mem_id_q         <= mem_id_d;
        end
    end

    // Writes are withheld while stalled so a frozen core never repeats an I/O byte.
    always_comb begin
        mem_wr   = (state_q == S_STORE) && !w_io_stall && rdy;
        mem_busy = (state_q == S_LOAD) || (state_q == S_STORE) || store_valid_q
                 || load_valid_q || lsb_mem_enable || rob_mem_enable;
    end

    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mc_inst        = mc_inst_q;
    assign mc_inst_ready  = mc_inst_ready_q;
    assign mem_data       = mem_data_q;
    assign mem_data_ready = mem_data_ready_q;
    assign mem_id         = mem_id_q;

endmodule

`default_nettype wire
